// File: rtl/fix_acc_sat.sv
// Windowed fixed-point accumulator: sums ACC_LEN products plus bias, saturates to WIDTH bits; result 1 clk after last accept.
// Holds result until out_ready; in_ready drops only while holding. Define FIX_ACC_RELU_EN to clamp negative results to 0.
module fix_acc_sat #(
  parameter int WIDTH       = 16,
  parameter int POINT_WIDTH = 8,
  parameter int ACC_LEN     = 25,
  parameter int ACC_WIDTH   = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_prod,
  input  logic [WIDTH-1:0]   bias,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               sat_flag
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // Products already carry the Q(POINT_WIDTH) scaling, so no alignment shift is needed.
  if (ACC_LEN < 1) begin : g_bad_len
    $error("fix_acc_sat: ACC_LEN must be >= 1");
  end
  if (ACC_WIDTH < 2*WIDTH + CNT_W + 1) begin : g_bad_acc
    $error("fix_acc_sat: ACC_WIDTH too narrow, accumulator could wrap");
  end
  if (POINT_WIDTH >= WIDTH) begin : g_bad_point
    $error("fix_acc_sat: POINT_WIDTH must be below WIDTH");
  end

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  typedef struct packed {
    logic             sat;
    logic [WIDTH-1:0] dat;
  } res_t;

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  bias_ext;
  logic signed [ACC_WIDTH-1:0]  acc_nxt;
  logic signed [ACC_WIDTH-1:0]  win_sum;
  logic                         accept;
  logic                         last;
  res_t                         res_sat;
  res_t                         res_nxt;

  assign in_ready = (state == ST_ACC) | out_ready;
  assign accept   = in_valid & in_ready & ~acc_clr;
  assign last     = accept & (cnt == CNT_LAST);

  assign prod_ext = {{(ACC_WIDTH-2*WIDTH){in_prod[2*WIDTH-1]}}, in_prod};
  assign bias_ext = {{(ACC_WIDTH-WIDTH){bias[WIDTH-1]}}, bias};
  assign acc_nxt  = acc + prod_ext;
  assign win_sum  = acc_nxt + bias_ext;

  always_comb begin
    res_sat = '0;
    if (win_sum > SAT_MAX) begin
      res_sat.sat = 1'b1;
      res_sat.dat = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (win_sum < SAT_MIN) begin
      res_sat.sat = 1'b1;
      res_sat.dat = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      res_sat.dat = win_sum[WIDTH-1:0];
    end
  end

`ifdef FIX_ACC_RELU_EN
  // sat_flag keeps reporting width clipping only; the ReLU clamp does not set it.
  always_comb begin
    res_nxt = res_sat;
    if (res_sat.dat[WIDTH-1]) res_nxt.dat = '0;
  end
`else
  assign res_nxt = res_sat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (acc_clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        if (last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
      end

      // A window finishing on the retire edge reloads HOLD directly.
      case (state)
        ST_ACC: begin
          if (last) begin
            out_data  <= res_nxt.dat;
            sat_flag  <= res_nxt.sat;
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (last) begin
            out_data  <= res_nxt.dat;
            sat_flag  <= res_nxt.sat;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_acc_sat.sv
// Scoreboard bench for fix_acc_sat with ACC_LEN=4: directed windows plus randomized traffic.
module tb_fix_acc_sat;

  localparam int ACC_LEN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_prod = '0;
  logic [15:0] bias = '0;
  logic        acc_clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        sat_flag;

  fix_acc_sat #(
    .WIDTH(16), .POINT_WIDTH(8), .ACC_LEN(ACC_LEN), .ACC_WIDTH(40)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .bias(bias),
    .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [16:0] exp_q[$];
  logic [16:0] last_res;
  longint      wsum = 0;
  int          wcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer window sum, then clip to signed 16 bits.
  function automatic logic [16:0] model_res(input longint s);
    logic [15:0] d;
    logic        f;
    if (s > 32767) begin
      d = 16'h7FFF; f = 1'b1;
    end else if (s < -32768) begin
      d = 16'h8000; f = 1'b1;
    end else begin
      d = s[15:0]; f = 1'b0;
    end
`ifdef FIX_ACC_RELU_EN
    if (d[15]) d = 16'h0000;
`endif
    return {f, d};
  endfunction

  // One clock of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic cyc(input logic v, input logic [31:0] p, input logic [15:0] b,
                     input logic clr, input logic ordy);
    logic exp_rdy;
    logic acc;
    in_valid = v; in_prod = p; bias = b; acc_clr = clr; out_ready = ordy;
    #2;
    exp_rdy = (exp_q.size() == 0) || ordy;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = v && exp_rdy && !clr;
    @(posedge clk);
    if (clr) begin
      wsum = 0; wcnt = 0;
    end else if (acc) begin
      wsum += longint'($signed(p));
      wcnt++;
      if (wcnt == ACC_LEN) begin
        exp_q.push_back(model_res(wsum + longint'($signed(b))));
        wsum = 0; wcnt = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    exp_q.delete(); wsum = 0; wcnt = 0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic window(input logic [31:0] p, input logic [15:0] b,
                        input string name, input logic [16:0] exp);
    last_res = 17'h1_5A5A;
    for (int i = 0; i < ACC_LEN; i++) cyc(1'b1, p, b, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 16'd0, 1'b0, 1'b1);
    chk(name, {15'd0, last_res}, {15'd0, exp});
  endtask

  // Monitor: outputs sampled on the falling edge, retired on a visible handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
        if (out_valid && exp_q.size() != 0) begin
          chk("result", {15'd0, sat_flag, out_data}, {15'd0, exp_q[0]});
          if (out_ready) begin
            last_res = {sat_flag, out_data};
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    logic [31:0] r;
    @(posedge clk); #1;
    do_reset();

    window(32'h0000_0100, 16'h0080, "t1_sum", 17'h0_0480);
    window(32'h0000_7000, 16'h0000, "t2_pos_sat", 17'h1_7FFF);
`ifdef FIX_ACC_RELU_EN
    window(32'hFFFF_FF00, 16'h0000, "t3_neg", 17'h0_0000);
`else
    window(32'hFFFF_FF00, 16'h0000, "t3_neg", 17'h0_FC00);
`endif
    window(32'h8000_0000, 16'h8000, "neg_sat", model_res(-64'sd8589967360));

    // Stall the result, then retire it while taking the next window's first product.
    for (int i = 0; i < ACC_LEN - 1; i++) cyc(1'b1, 32'h100, 16'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h100, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h100, 16'h0, 1'b0, 1'b0);
    last_res = 17'h1_5A5A;
    cyc(1'b1, 32'h100, 16'h0, 1'b0, 1'b1);
    chk("t4_retired", {15'd0, last_res}, 32'h0400);
    last_res = 17'h1_5A5A;
    for (int i = 0; i < ACC_LEN - 1; i++) cyc(1'b1, 32'h100, 16'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 16'd0, 1'b0, 1'b1);
    chk("t4_next", {15'd0, last_res}, 32'h0400);

    // Abort a partial window; the product presented with acc_clr is dropped.
    cyc(1'b1, 32'h100, 16'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h100, 16'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h7000, 16'h0, 1'b1, 1'b1);
    window(32'h0000_0100, 16'h0000, "t5_clr", 17'h0_0400);

    // Reset mid-window.
    cyc(1'b1, 32'h100, 16'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h100, 16'h0, 1'b0, 1'b1);
    do_reset();
    window(32'h0000_0100, 16'h0000, "t6_rst", 17'h0_0400);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      case ($urandom_range(0, 2))
        0: p = {{22{r[9]}}, r[9:0]};
        1: p = {{15{r[16]}}, r[16:0]};
        default: p = r;
      endcase
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 9) < 8, p, 16'($urandom),
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(1'b0, 32'd0, 16'd0, 1'b0, 1'b1);
    chk("drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
